// File: rtl/inst_sram_ctrl.sv
// Single-port asynchronous SRAM controller shared between icache line refill and MEM-stage
// load/store. Data accesses win arbitration; strobes are decoded from the FSM state.
module inst_sram_ctrl #(
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned RD_WAIT = 1,
   parameter int unsigned WR_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [31:0]       inst_addr,
   output logic [31:0]       inst_i,
   output logic              inst_stop,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [3:0]        data_be,
   input  logic [31:0]       data_addr,
   input  logic [31:0]       data_wdata,
   output logic [31:0]       data_rdata,
   output logic              data_ready,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [31:0]       ram_dq_i,
   output logic [31:0]       ram_dq_o,
   output logic              ram_dq_oe,
   output logic              ram_ce_n,
   output logic              ram_oe_n,
   output logic              ram_we_n,
   output logic [3:0]        ram_be_n
);

   typedef enum logic [2:0] {
      StIdle,
      StInstRd,
      StInstDone,
      StDataRd,
      StDataWr,
      StWrEnd,
      StDataDone
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q;
   logic [31:0]       inst_addr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [31:0]       inst_q;
   logic [31:0]       rdata_q;
   logic              rd_last;
   logic              wr_last;
   logic              unused_addr_bits;

   assign rd_last = (cnt_q == 3'(RD_WAIT - 1));
   assign wr_last = (cnt_q == 3'(WR_WAIT - 1));

   // Byte offset and bits above the SRAM word range are don't-care on the data port.
   assign unused_addr_bits = ^{data_addr[31:ADDR_W+2], data_addr[1:0]};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (data_req) begin
               state_d = data_we ? StDataWr : StDataRd;
            end else if (inst_req) begin
               state_d = StInstRd;
            end
         end
         StInstRd:   if (rd_last) state_d = StInstDone;
         StInstDone: state_d = StIdle;
         StDataRd:   if (rd_last) state_d = StDataDone;
         StDataWr:   if (wr_last) state_d = StWrEnd;
         StWrEnd:    state_d = StDataDone;
         StDataDone: state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Wait counter restarts on every state entry and only runs in strobe states.
   always_ff @(posedge clk) begin
      if (rst || (state_d != state_q)) begin
         cnt_q <= '0;
      end else if (state_q == StInstRd || state_q == StDataRd || state_q == StDataWr) begin
         cnt_q <= cnt_q + 3'd1;
      end
   end

   // Request capture and read-data latching
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_addr_q <= '0;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         inst_q      <= '0;
         rdata_q     <= '0;
      end else begin
         if (state_q == StIdle) begin
            if (data_req) begin
               addr_q  <= data_addr[ADDR_W+1:2];
               be_q    <= data_be;
               wdata_q <= data_wdata;
            end else if (inst_req) begin
               addr_q      <= inst_addr[ADDR_W+1:2];
               inst_addr_q <= inst_addr;
            end
         end
         if (state_q == StInstRd && rd_last) begin
            inst_q <= ram_dq_i;
         end
         if (state_q == StDataRd && rd_last) begin
            rdata_q <= ram_dq_i;
         end
      end
   end

   // Output decode
   always_comb begin
      ram_ce_n   = 1'b1;
      ram_oe_n   = 1'b1;
      ram_we_n   = 1'b1;
      ram_be_n   = 4'hF;
      ram_dq_oe  = 1'b0;
      data_ready = 1'b0;
      unique case (state_q)
         StInstRd: begin
            ram_ce_n = 1'b0;
            ram_oe_n = 1'b0;
            ram_be_n = 4'h0;
         end
         StDataRd: begin
            ram_ce_n = 1'b0;
            ram_oe_n = 1'b0;
            ram_be_n = ~be_q;
         end
         StDataWr: begin
            ram_ce_n  = 1'b0;
            ram_we_n  = 1'b0;
            ram_be_n  = ~be_q;
            ram_dq_oe = 1'b1;
         end
         StWrEnd: begin
            // we_n released one cycle before ce_n/data so the SRAM sees hold time.
            ram_ce_n  = 1'b0;
            ram_be_n  = ~be_q;
            ram_dq_oe = 1'b1;
         end
         StDataDone: data_ready = 1'b1;
         default: ;
      endcase
   end

   // A refill word is only handed over if the icache still wants the same address.
   assign inst_stop  = inst_req && !(state_q == StInstDone && inst_addr == inst_addr_q);
   assign inst_i     = inst_q;
   assign data_rdata = rdata_q;
   assign ram_addr   = addr_q;
   assign ram_dq_o   = wdata_q;

endmodule

// File: tb/tb_inst_sram_ctrl.sv
// Directed bench for inst_sram_ctrl with a behavioural asynchronous SRAM model.
module tb_inst_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_i;
   logic        inst_stop;
   logic        data_req;
   logic        data_we;
   logic [3:0]  data_be;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_ready;
   logic [19:0] ram_addr;
   logic [31:0] ram_dq_i;
   logic [31:0] ram_dq_o;
   logic        ram_dq_oe;
   logic        ram_ce_n;
   logic        ram_oe_n;
   logic        ram_we_n;
   logic [3:0]  ram_be_n;

   logic [31:0] mem [0:255];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          we_low_cnt = 0;
   int          overlap_cnt = 0;
   int          ready_cnt = 0;
   int          snap;

   inst_sram_ctrl #(
      .ADDR_W  (20),
      .RD_WAIT (1),
      .WR_WAIT (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_i     (inst_i),
      .inst_stop  (inst_stop),
      .data_req   (data_req),
      .data_we    (data_we),
      .data_be    (data_be),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_ready (data_ready),
      .ram_addr   (ram_addr),
      .ram_dq_i   (ram_dq_i),
      .ram_dq_o   (ram_dq_o),
      .ram_dq_oe  (ram_dq_oe),
      .ram_ce_n   (ram_ce_n),
      .ram_oe_n   (ram_oe_n),
      .ram_we_n   (ram_we_n),
      .ram_be_n   (ram_be_n)
   );

   always #5 clk = ~clk;

   assign ram_dq_i = mem[ram_addr[7:0]];

   always @(posedge clk) begin
      if (!ram_ce_n && !ram_we_n) begin
         for (int b = 0; b < 4; b++) begin
            if (!ram_be_n[b]) mem[ram_addr[7:0]][8*b +: 8] = ram_dq_o[8*b +: 8];
         end
      end
   end

   always @(negedge clk) begin
      if (!ram_oe_n && !ram_we_n) overlap_cnt++;
      if (!ram_we_n) we_low_cnt++;
      if (data_ready) ready_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[4]  = 32'h2408_0001;
      mem[5]  = 32'h8C09_0004;
      mem[8]  = 32'h1122_3344;
      mem[12] = 32'h5566_7788;
      rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
      data_be = '0; data_addr = '0; data_wdata = '0;

      tick(); tick(); #1;
      chk("rst_inst_stop", 32'(inst_stop), 32'h0);
      chk("rst_data_ready", 32'(data_ready), 32'h0);
      chk("rst_strobes", 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe}), 32'hE);
      chk("rst_be_n", 32'(ram_be_n), 32'hF);
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_inst_i", inst_i, 32'h0);
      chk("rst_data_rdata", data_rdata, 32'h0);

      // Scenario 1: plain fetch, two-cycle latency
      tick(); rst = 1'b0; inst_req = 1'b1; inst_addr = 32'h8000_0010; snap = we_low_cnt; #1;
      chk("s1_t0_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s1_t1_stop", 32'(inst_stop), 32'h1);
      chk("s1_t1_ce_oe", 32'({ram_ce_n, ram_oe_n}), 32'h0);
      chk("s1_t1_be_n", 32'(ram_be_n), 32'h0);
      chk("s1_t1_addr", 32'(ram_addr), 32'h4);
      tick(); #1;
      chk("s1_t2_stop", 32'(inst_stop), 32'h0);
      chk("s1_t2_inst", inst_i, 32'h2408_0001);
      tick(); inst_req = 1'b0; #1;
      chk("s1_we_never_low", 32'(we_low_cnt - snap), 32'h0);

      // Scenario 2: partial write then readback
      tick(); data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
      data_addr = 32'h8000_0020; data_wdata = 32'hAABB_CCDD; #1;
      chk("s2_t0_ready", 32'(data_ready), 32'h0);
      tick(); #1;
      chk("s2_t1_we_ce", 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe}), 32'h5);
      chk("s2_t1_be_n", 32'(ram_be_n), 32'hC);
      chk("s2_t1_addr", 32'(ram_addr), 32'h8);
      chk("s2_t1_dq", ram_dq_o, 32'hAABB_CCDD);
      tick(); #1;
      chk("s2_t2_we", 32'(ram_we_n), 32'h0);
      tick(); #1;
      chk("s2_t3_wrend", 32'({ram_ce_n, ram_oe_n, ram_we_n, ram_dq_oe}), 32'h7);
      chk("s2_t3_ready", 32'(data_ready), 32'h0);
      tick(); #1;
      chk("s2_t4_ready", 32'(data_ready), 32'h1);
      chk("s2_t4_strobes", 32'({ram_ce_n, ram_we_n, ram_dq_oe}), 32'h6);
      tick(); data_req = 1'b0; #1;
      tick(); data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; #1;
      tick(); #1;
      chk("s2_rd_oe", 32'({ram_ce_n, ram_oe_n, ram_we_n}), 32'h1);
      chk("s2_rd_be_n", 32'(ram_be_n), 32'h0);
      tick(); #1;
      chk("s2_rd_ready", 32'(data_ready), 32'h1);
      chk("s2_rd_data", data_rdata, 32'h1122_CCDD);
      tick(); data_req = 1'b0; #1;

      // Scenario 3: simultaneous requests, data first
      tick(); data_req = 1'b1; inst_req = 1'b1; inst_addr = 32'h8000_0010; #1;
      chk("s3_t0_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s3_t1_data_rd", 32'({ram_oe_n, ram_be_n}), 32'h0);
      chk("s3_t1_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s3_t2_ready", 32'(data_ready), 32'h1);
      chk("s3_t2_stop", 32'(inst_stop), 32'h1);
      chk("s3_t2_rdata", data_rdata, 32'h1122_CCDD);
      tick(); data_req = 1'b0; #1;
      chk("s3_t3_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s3_t4_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s3_t5_stop", 32'(inst_stop), 32'h0);
      chk("s3_t5_inst", inst_i, 32'h2408_0001);
      tick(); inst_req = 1'b0; #1;

      // Scenario 4: address changes mid-fetch
      tick(); inst_req = 1'b1; inst_addr = 32'h8000_0010; #1;
      tick(); #1;
      chk("s4_t1_addr", 32'(ram_addr), 32'h4);
      inst_addr = 32'h8000_0014;
      tick(); #1;
      chk("s4_t2_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s4_t3_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s4_t4_addr", 32'(ram_addr), 32'h5);
      tick(); #1;
      chk("s4_t5_stop", 32'(inst_stop), 32'h0);
      chk("s4_t5_inst", inst_i, 32'h8C09_0004);
      tick(); inst_req = 1'b0; #1;

      // Scenario 5: reset during a write
      tick(); data_req = 1'b1; data_we = 1'b1; data_be = 4'hF;
      data_addr = 32'h8000_0030; data_wdata = 32'hDEAD_BEEF; snap = ready_cnt; #1;
      tick(); #1;
      chk("s5_t1_we", 32'(ram_we_n), 32'h0);
      rst = 1'b1;
      tick(); rst = 1'b0; data_req = 1'b0; #1;
      chk("s5_abort_strobes", 32'({ram_ce_n, ram_we_n, ram_dq_oe}), 32'h6);
      chk("s5_abort_addr", 32'(ram_addr), 32'h0);
      tick(); tick(); tick(); #1;
      chk("s5_no_ready", 32'(ready_cnt - snap), 32'h0);
      tick(); inst_req = 1'b1; inst_addr = 32'h8000_0010; #1;
      chk("s5_f_t0_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s5_f_t1_stop", 32'(inst_stop), 32'h1);
      tick(); #1;
      chk("s5_f_t2_stop", 32'(inst_stop), 32'h0);
      chk("s5_f_t2_inst", inst_i, 32'h2408_0001);
      tick(); inst_req = 1'b0; #1;

      chk("oe_we_overlap", 32'(overlap_cnt), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
